// File: rtl/response_statistics_if.sv
`default_nettype none
// ============================================================================
// Module   : response_statistics_if
// Purpose  : Response-stream and MMIO-readback bus for response_statistics_engine.
// Revision : 1.0 - initial release
// ============================================================================
interface response_statistics_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 32
);
    localparam int c_ch_w = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                               enabled_in;
    logic                               clear_in;
    logic [NUM_CHANNELS-1:0]            response_valid_in;
    logic [NUM_CHANNELS-1:0][7:0]       response_code_in;
    logic [NUM_CHANNELS-1:0][7:0]       response_tag_cmd_type_in;
    logic                               rd_req_in;
    logic [c_ch_w-1:0]                  rd_channel_in;
    logic [3:0]                         rd_index_in;
    logic                               rd_valid_out;
    logic [COUNT_WIDTH-1:0]             rd_data_out;
    logic [NUM_CHANNELS-1:0]            overflow_out;

    modport master (
        output enabled_in, clear_in, response_valid_in, response_code_in,
               response_tag_cmd_type_in, rd_req_in, rd_channel_in, rd_index_in,
        input  rd_valid_out, rd_data_out, overflow_out
    );

    modport slave (
        input  enabled_in, clear_in, response_valid_in, response_code_in,
               response_tag_cmd_type_in, rd_req_in, rd_channel_in, rd_index_in,
        output rd_valid_out, rd_data_out, overflow_out
    );
endinterface
`default_nettype wire

// File: rtl/response_statistics_engine.sv
`default_nettype none
// ============================================================================
// Module   : response_statistics_engine
// Purpose  : Per-channel PSL response-code counters with sticky overflow and a
//            registered indexed read port. Define RESP_STATS_SATURATE_EN for
//            saturating counters (default: wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module response_statistics_engine #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 32
) (
    input  wire logic             clock,
    input  wire logic             rstn,
    response_statistics_if.slave  bus
);
    localparam int             c_ch_w        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int             c_num_idx     = 11;
    localparam logic [7:0]     c_resp_done    = 8'h00;
    localparam logic [7:0]     c_resp_aerror  = 8'h01;
    localparam logic [7:0]     c_resp_derror  = 8'h03;
    localparam logic [7:0]     c_resp_nlock   = 8'h04;
    localparam logic [7:0]     c_resp_nres    = 8'h05;
    localparam logic [7:0]     c_resp_flushed = 8'h06;
    localparam logic [7:0]     c_resp_fault   = 8'h07;
    localparam logic [7:0]     c_resp_failed  = 8'h08;
    localparam logic [7:0]     c_resp_paged   = 8'h0A;
    localparam logic [7:0]     c_cmd_restart  = 8'h01;
    localparam logic [7:0]     c_cmd_prefetch = 8'h02;

    logic                                enabled_q;
    logic [NUM_CHANNELS-1:0]             valid_q;
    logic [NUM_CHANNELS-1:0][7:0]        code_q;
    logic [NUM_CHANNELS-1:0][7:0]        cmd_q;
    logic [NUM_CHANNELS-1:0][c_num_idx-1:0] hit_d;
    logic [COUNT_WIDTH-1:0]              cnt_q [NUM_CHANNELS][c_num_idx];
    logic [NUM_CHANNELS-1:0]             overflow_q;
    logic                                rd_valid_q;
    logic [COUNT_WIDTH-1:0]              rd_data_q;
    logic [COUNT_WIDTH-1:0]              rd_data_d;

    // Stage 0/1: registered enable, then per-channel response capture.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q <= 1'b0;
            valid_q   <= '0;
            code_q    <= '0;
            cmd_q     <= '0;
        end else begin
            enabled_q <= bus.enabled_in;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (enabled_q && bus.response_valid_in[c]) begin
                    valid_q[c] <= 1'b1;
                    code_q[c]  <= bus.response_code_in[c];
                    cmd_q[c]   <= bus.response_tag_cmd_type_in[c];
                end else begin
                    valid_q[c] <= 1'b0;
                    code_q[c]  <= '0;
                    cmd_q[c]   <= '0;
                end
            end
        end
    end

    // Stage 2 decode: one-hot counter select per channel; unknown codes select nothing.
    always_comb begin
        hit_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (valid_q[c]) begin
                case (code_q[c])
                    c_resp_done: begin
                        if (cmd_q[c] == c_cmd_restart)       hit_d[c][1] = 1'b1;
                        else if (cmd_q[c] == c_cmd_prefetch) hit_d[c][2] = 1'b1;
                        else                                 hit_d[c][0] = 1'b1;
                    end
                    c_resp_flushed: hit_d[c][3]  = 1'b1;
                    c_resp_paged:   hit_d[c][4]  = 1'b1;
                    c_resp_aerror:  hit_d[c][5]  = 1'b1;
                    c_resp_derror:  hit_d[c][6]  = 1'b1;
                    c_resp_failed:  hit_d[c][7]  = 1'b1;
                    c_resp_fault:   hit_d[c][8]  = 1'b1;
                    c_resp_nres:    hit_d[c][9]  = 1'b1;
                    c_resp_nlock:   hit_d[c][10] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Clear takes priority over any increment landing on the same edge.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int i = 0; i < c_num_idx; i++)
                    cnt_q[c][i] <= '0;
            overflow_q <= '0;
        end else if (bus.clear_in) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int i = 0; i < c_num_idx; i++)
                    cnt_q[c][i] <= '0;
            overflow_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int i = 0; i < c_num_idx; i++) begin
                    if (hit_d[c][i]) begin
                        if (&cnt_q[c][i]) overflow_q[c] <= 1'b1;
`ifdef RESP_STATS_SATURATE_EN
                        if (!(&cnt_q[c][i])) cnt_q[c][i] <= cnt_q[c][i] + COUNT_WIDTH'(1);
`else
                        cnt_q[c][i] <= cnt_q[c][i] + COUNT_WIDTH'(1);
`endif
                    end
                end
            end
        end
    end

    // Out-of-range channel or unmapped index falls through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int i = 0; i < c_num_idx; i++)
                if (bus.rd_channel_in == c_ch_w'(c) && bus.rd_index_in == 4'(i))
                    rd_data_d = cnt_q[c][i];
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req_in;
            if (bus.rd_req_in) rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_valid_out = rd_valid_q;
    assign bus.rd_data_out  = rd_data_q;
    assign bus.overflow_out = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_response_statistics_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_statistics_engine
// Purpose  : Directed self-checking bench for response_statistics_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_statistics_engine;
    logic clock;
    logic rstn;
    int   n_pass  = 0;
    int   n_total = 0;

    response_statistics_if #(.NUM_CHANNELS(4), .COUNT_WIDTH(8)) bus_a ();
    response_statistics_if #(.NUM_CHANNELS(3), .COUNT_WIDTH(8)) bus_b ();

    response_statistics_engine #(.NUM_CHANNELS(4), .COUNT_WIDTH(8)) u_dut_a (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus_a.slave)
    );

    response_statistics_engine #(.NUM_CHANNELS(3), .COUNT_WIDTH(8)) u_dut_b (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input int ch, input logic [7:0] code, input logic [7:0] cmd, input int n);
        for (int k = 0; k < n; k++) begin
            bus_a.response_valid_in[ch]        = 1'b1;
            bus_a.response_code_in[ch]         = code;
            bus_a.response_tag_cmd_type_in[ch] = cmd;
            tick();
        end
        bus_a.response_valid_in[ch] = 1'b0;
    endtask

    task automatic read_a(input string tag, input int ch, input int idx, input logic [7:0] exp);
        bus_a.rd_req_in     = 1'b1;
        bus_a.rd_channel_in = 2'(ch);
        bus_a.rd_index_in   = 4'(idx);
        tick();
        check({tag, "_valid"}, 64'(bus_a.rd_valid_out), 64'd1);
        check({tag, "_data"},  64'(bus_a.rd_data_out),  64'(exp));
        bus_a.rd_req_in = 1'b0;
    endtask

    logic [7:0] exp0 [11];

    initial begin
        rstn = 1'b0;
        bus_a.enabled_in = 1'b0; bus_a.clear_in = 1'b0; bus_a.response_valid_in = '0;
        bus_a.response_code_in = '0; bus_a.response_tag_cmd_type_in = '0;
        bus_a.rd_req_in = 1'b0; bus_a.rd_channel_in = '0; bus_a.rd_index_in = '0;
        bus_b.enabled_in = 1'b0; bus_b.clear_in = 1'b0; bus_b.response_valid_in = '0;
        bus_b.response_code_in = '0; bus_b.response_tag_cmd_type_in = '0;
        bus_b.rd_req_in = 1'b0; bus_b.rd_channel_in = '0; bus_b.rd_index_in = '0;

        tick(); tick();
        check("rst_rd_valid", 64'(bus_a.rd_valid_out), 64'd0);
        check("rst_rd_data",  64'(bus_a.rd_data_out),  64'd0);
        check("rst_overflow", 64'(bus_a.overflow_out), 64'd0);
        rstn = 1'b1;
        tick();

        // Responses before enable are ignored.
        send_a(0, 8'h00, 8'h00, 2);
        tick(); tick();
        read_a("pre_enable_done", 0, 0, 8'd0);

        // Test 1: ch0 mixed DONE / DONE_RESTART / PAGED.
        bus_a.enabled_in = 1'b1;
        bus_b.enabled_in = 1'b1;
        tick();
        send_a(0, 8'h00, 8'h00, 3);
        send_a(0, 8'h00, 8'h01, 1);
        send_a(0, 8'h0A, 8'h00, 2);
        tick(); tick();
        exp0 = '{8'd3, 8'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 11; i++) read_a($sformatf("t1_ch0_idx%0d", i), 0, i, exp0[i]);
        for (int c = 1; c < 4; c++)
            for (int i = 0; i < 11; i++) read_a($sformatf("t1_ch%0d_idx%0d", c, i), c, i, 8'd0);

        // Test 2: FAULT on all channels at once; exact read latency.
        for (int c = 0; c < 4; c++) begin
            bus_a.response_valid_in[c] = 1'b1;
            bus_a.response_code_in[c]  = 8'h07;
            bus_a.response_tag_cmd_type_in[c] = 8'h00;
        end
        bus_a.rd_req_in = 1'b1; bus_a.rd_channel_in = 2'd0; bus_a.rd_index_in = 4'd8;
        tick();
        bus_a.response_valid_in = '0;
        check("t2_lat0_valid", 64'(bus_a.rd_valid_out), 64'd1);
        check("t2_lat0_data",  64'(bus_a.rd_data_out),  64'd0);
        tick();
        check("t2_lat1_preupdate", 64'(bus_a.rd_data_out), 64'd0);
        tick();
        check("t2_lat2_data", 64'(bus_a.rd_data_out), 64'd1);
        bus_a.rd_req_in = 1'b0;
        tick();
        check("t2_idle_valid", 64'(bus_a.rd_valid_out), 64'd0);
        check("t2_idle_hold",  64'(bus_a.rd_data_out),  64'd1);
        for (int c = 1; c < 4; c++) read_a($sformatf("t2_ch%0d_fault", c), c, 8, 8'd1);

        // Test 3: 257 AERROR on ch1 with 8-bit counters.
        check("t3_ovf_before", 64'(bus_a.overflow_out), 64'd0);
        send_a(1, 8'h01, 8'h00, 257);
        tick(); tick();
`ifdef RESP_STATS_SATURATE_EN
        read_a("t3_aerror", 1, 5, 8'd255);
`else
        read_a("t3_aerror", 1, 5, 8'd1);
`endif
        check("t3_overflow", 64'(bus_a.overflow_out), 64'h2);

        // Test 4: clear on the same edge as an NRES stage-2 update.
        send_a(3, 8'h05, 8'h00, 1);
        bus_a.clear_in = 1'b1;
        tick();
        bus_a.clear_in = 1'b0;
        tick(); tick();
        read_a("t4_nres_cleared", 3, 9, 8'd0);
        check("t4_overflow", 64'(bus_a.overflow_out), 64'd0);
        read_a("t4_aerror_cleared", 1, 5, 8'd0);
        read_a("t4_done_cleared", 0, 0, 8'd0);
        send_a(3, 8'h05, 8'h00, 1);
        tick(); tick();
        read_a("t4_nres_after", 3, 9, 8'd1);

        // Test 5: disabled responses do not count, counters hold.
        send_a(2, 8'h06, 8'h00, 2);
        bus_a.enabled_in = 1'b0;
        tick();
        send_a(2, 8'h06, 8'h00, 10);
        tick(); tick();
        read_a("t5_flushed_hold", 2, 3, 8'd2);
        bus_a.enabled_in = 1'b1;
        tick();
        send_a(2, 8'h06, 8'h00, 1);
        tick(); tick();
        read_a("t5_flushed_resume", 2, 3, 8'd3);

        // Test 6: unmapped index and out-of-range channel read as zero.
        read_a("t6_idx12", 2, 12, 8'd0);
        read_a("t5_flushed_again", 2, 3, 8'd3);
        read_a("t6_idx15", 2, 15, 8'd0);
        bus_b.response_valid_in[2] = 1'b1;
        bus_b.response_code_in[2]  = 8'h00;
        tick();
        bus_b.response_valid_in = '0;
        tick(); tick();
        bus_b.rd_req_in = 1'b1; bus_b.rd_channel_in = 2'd2; bus_b.rd_index_in = 4'd0;
        tick();
        check("t6_b_ch2_valid", 64'(bus_b.rd_valid_out), 64'd1);
        check("t6_b_ch2_data",  64'(bus_b.rd_data_out),  64'd1);
        bus_b.rd_channel_in = 2'd3;
        tick();
        check("t6_b_ch3_valid", 64'(bus_b.rd_valid_out), 64'd1);
        check("t6_b_ch3_data",  64'(bus_b.rd_data_out),  64'd0);
        bus_b.rd_req_in = 1'b0;

        // Test 7: asynchronous reset in the middle of traffic.
        for (int c = 0; c < 4; c++) begin
            bus_a.response_valid_in[c] = 1'b1;
            bus_a.response_code_in[c]  = 8'h00;
            bus_a.response_tag_cmd_type_in[c] = 8'h00;
        end
        bus_a.rd_req_in = 1'b1; bus_a.rd_channel_in = 2'd2; bus_a.rd_index_in = 4'd3;
        tick();
        check("t7_pre_valid", 64'(bus_a.rd_valid_out), 64'd1);
        check("t7_pre_data",  64'(bus_a.rd_data_out),  64'd3);
        #2;
        rstn = 1'b0;
        #1;
        check("t7_rst_valid",    64'(bus_a.rd_valid_out), 64'd0);
        check("t7_rst_data",     64'(bus_a.rd_data_out),  64'd0);
        check("t7_rst_overflow", 64'(bus_a.overflow_out), 64'd0);
        bus_a.response_valid_in = '0;
        bus_a.rd_req_in = 1'b0;
        tick();
        rstn = 1'b1;
        tick(); tick();
        read_a("t7_flushed_reset", 2, 3, 8'd0);
        read_a("t7_done_reset", 0, 0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/response_statistics_engine.md
# response_statistics_engine

Parametrised, multi-channel successor to the single-stream response counter. Tallies PSL response codes per channel (NUM_CHANNELS independent response streams, e.g. read/write/restart engines), with configurable counter width, synchronous clear, sticky overflow flags and a registered indexed read port for MMIO readback. Sits beside the AFU control/MMIO block, fed by each channel's response interface and tag-lookup result.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of independent response streams (1..16)
- COUNT_WIDTH, 32, width of each counter (8..64)

Ports (clock and reset: clock clock; reset rstn, asynchronous, active-low):
- clock  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  counting enable, registered internally
- clear_in  in  1  single-cycle pulse: zero all counters and overflow flags
- response_in  in  [NUM_CHANNELS] ResponseInterface  per-channel response (valid, response code)
- response_tag_id_in  in  [NUM_CHANNELS] CommandTagLine  per-channel tag line, aligned with response_in
- rd_req_in  in  1  read request strobe
- rd_channel_in  in  max(1,$clog2(NUM_CHANNELS))  channel to read
- rd_index_in  in  4  counter index (encoding below)
- rd_valid_out  out  1  read data valid
- rd_data_out  out  COUNT_WIDTH  counter value
- overflow_out  out  NUM_CHANNELS  sticky per-channel overflow flag

## Operation
- Counter index per channel: 0 DONE, 1 DONE_RESTART, 2 DONE_PREFETCH, 3 FLUSHED, 4 PAGED, 5 AERROR, 6 DERROR, 7 FAILED, 8 FAULT, 9 NRES, 10 NLOCK; 11-15 unmapped.
- Stage 0: enabled <= enabled_in.
- Stage 1 (per channel): if enabled and response_in[c].valid, latch response and tag cmd_type; else latch zero.
- Stage 2 (per channel): if latched valid, decode: DONE with cmd_type CMD_RESTART -> idx 1; DONE with CMD_PREFETCH -> idx 2; other DONE -> idx 0; others per table; unknown code -> no update.
- Channels update in parallel; each channel updates at most one counter per cycle.
- enabled low: stage-1 latch forced to zero; counters and flags hold (not cleared).
- clear_in high: all counters and overflow_out zeroed at that edge; a stage-2 increment on the same edge is dropped (clear wins). Stage-1 contents are not flushed.
- Increment at all-ones: behaviour per Configuration; overflow_out[c] set, stays set until clear_in or reset.
- Read: rd_req_in sampled at edge N -> rd_valid_out=1 and rd_data_out=counter[rd_channel_in][rd_index_in] after edge N, for one cycle. Unmapped index or rd_channel_in >= NUM_CHANNELS -> rd_data_out=0, rd_valid_out still 1. Reads never stall; back-to-back reads allowed every cycle.
- rd_data_out returns the pre-update value if the counter is incremented on the same edge.

## Timing
- Reset: all counters 0, overflow_out 0, rd_valid_out 0, rd_data_out 0, enabled 0, stage-1 latches 0.
- enabled_in high at edge K -> responses sampled at edge K+1 onward are counted.
- Response valid at edge N -> counter updated at edge N+1 -> readable by rd_req_in at edge N+2 (data out after N+2).
- Read latency: 1 cycle. rd_data_out holds last value when rd_valid_out low.
- Reset mid-operation: immediate asynchronous return to reset values; in-flight responses lost.

## Configuration
- RESP_STATS_SATURATE_EN defined: counters saturate at 2^COUNT_WIDTH-1 (further increments ignored), overflow flag set on first blocked increment.
- Not defined: counters wrap to 0; overflow flag set on the wrapping increment.

## Test plan
- Reset, enable, ch0 sends 3 DONE (cmd_type normal), 1 DONE CMD_RESTART, 2 PAGED -> reads ch0 idx0=3, idx1=1, idx4=2, others 0; other channels all 0.
- All 4 channels each send 1 FAULT on the same cycle -> each channel idx8=1; read latency exactly 1 cycle, counter visible 2 cycles after input.
- COUNT_WIDTH=8, 257 AERROR on ch1 -> with RESP_STATS_SATURATE_EN idx5=255, overflow_out=4'b0010; without, idx5=1, overflow_out=4'b0010.
- clear_in pulsed on the same edge a stage-2 NRES update lands -> idx9 reads 0, overflow_out 0; next NRES -> 1.
- enabled_in low, 10 FLUSHED on ch2 -> idx3 unchanged; re-enable, 1 FLUSHED -> idx3 +1.
- Read rd_index_in=12 and rd_channel_in=NUM_CHANNELS -> rd_valid_out=1, rd_data_out=0; rstn asserted mid-traffic -> all outputs 0 immediately.
